// File: rtl/imem_wb_slave.sv
// Wishbone classic slave serving 16-bit big-endian instruction halfwords from an
// on-chip RAM, with programmable wait states and error termination for bad addresses.
`timescale 1ns/1ps

module imem_wb_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned WAIT_STATES  = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Per-lane merge of new write data over the stored word; sel[1] owns the even byte.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  sel);
    merge_lanes = {(sel[1] ? new_w[15:8] : old_w[15:8]),
                   (sel[0] ? new_w[7:0]  : old_w[7:0])};
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ack_q, err_q, ack_d, err_d;
  logic [15:0]           dat_q;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  bad_q;
  logic                  we_q;
  logic [1:0]            sel_q;
  logic [15:0]           wdat_q;

  logic [15:0]           mem [DEPTH];

  logic [31:0]           off, off_sh;
  logic                  req_bad;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  accept;

  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  resp_bad;
  logic                  resp_we;
  logic                  dat_load;
  logic                  wr_commit;

  // Addresses below BASE wrap to huge offsets and fall out of range on their own.
  assign off     = wb_adr_i - BASE_ADDRESS;
  assign off_sh  = off >> 1;
  assign req_bad = wb_adr_i[0] | (off_sh >= DEPTH_W);
  assign req_idx = off_sh[DEPTH_LOG2-1:0];
  assign accept  = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_en    = 1'b0;
    rd_idx   = idx_q;
    resp_bad = bad_q;
    resp_we  = we_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WS == 4'd0) begin
            // No wait states: the live request goes straight to the response cycle.
            state_d  = S_RESP;
            rd_en    = 1'b1;
            rd_idx   = req_idx;
            resp_bad = req_bad;
            resp_we  = wb_we_i;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign ack_d     = (state_d == S_RESP) && !resp_bad;
  assign err_d     = (state_d == S_RESP) &&  resp_bad;
  assign dat_load  = rd_en && !resp_bad && !resp_we;
  assign wr_commit = (state_q == S_RESP) && we_q && !bad_q;

  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (dat_load) begin
        dat_q <= mem[rd_idx];
      end
    end
  end

  // Request latch; later bus changes cannot disturb an accepted transfer
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q  <= req_idx;
      bad_q  <= req_bad;
      we_q   <= wb_we_i;
      sel_q  <= wb_sel_i;
      wdat_q <= wb_dat_i;
    end
  end

  // RAM write port
  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      mem[idx_q] <= merge_lanes(mem[idx_q], wdat_q, sel_q);
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_imem_wb_slave.sv
// Scoreboard bench for imem_wb_slave: four instances with WAIT_STATES 0..3 share one
// bus; only the targeted instance sees cyc.
`timescale 1ns/1ps

module tb_imem_wb_slave;

  typedef struct {
    int          w;
    logic        err;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] b_adr;
  logic [15:0] b_dat;
  logic [1:0]  b_sel;
  logic        b_we, b_stb, b_cyc;
  int          tgt;

  logic        cyc_v [4];
  logic        ack_v [4];
  logic        err_v [4];
  logic [15:0] dat_v [4];

  int          cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          resp_cnt [4];
  logic [15:0] last_dat [4];
  exp_t        sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign cyc_v[g] = b_cyc && (tgt == g);
    imem_wb_slave #(
      .BASE_ADDRESS(32'h0000_1000),
      .DEPTH_LOG2  (12),
      .WAIT_STATES (g),
      .INIT_FILE   ("")
    ) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .wb_adr_i(b_adr),
      .wb_dat_i(b_dat),
      .wb_dat_o(dat_v[g]),
      .wb_sel_i(b_sel),
      .wb_we_i (b_we),
      .wb_stb_i(b_stb),
      .wb_cyc_i(cyc_v[g]),
      .wb_ack_o(ack_v[g]),
      .wb_err_o(err_v[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
        if (ack_v[w] || err_v[w]) begin
          resp_cnt[w]++;
          checks++;
          if (ack_v[w] && err_v[w]) begin
            errors++;
            $display("FAIL ack_err_both: inst %0d cycle %0d", w, cnt);
          end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: inst %0d ack=%0b err=%0b cycle %0d", w, ack_v[w], err_v[w], cnt);
          end else begin
            e = sb.pop_front();
            if (e.w != w || e.err != err_v[w] || e.dat !== dat_v[w] || e.cyc != cnt) begin
              errors++;
              $display("FAIL resp: got inst=%0d err=%0b dat=%h cycle=%0d want inst=%0d err=%0b dat=%h cycle=%0d",
                       w, err_v[w], dat_v[w], cnt, e.w, e.err, e.dat, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // Called at a negedge with the target idle at the next edge; returns one cycle after the response.
  task automatic xfer(input int w, input logic [31:0] adr, input logic we, input logic [1:0] sel,
                      input logic [15:0] wdat, input logic exp_err, input logic [15:0] rdat,
                      input logic keep);
    exp_t e;
    bit   got;
    e.w   = w;
    e.err = exp_err;
    e.dat = (we || exp_err) ? last_dat[w] : rdat;
    e.cyc = cnt + 1 + w;
    if (!we && !exp_err) last_dat[w] = rdat;
    b_adr = adr; b_we = we; b_sel = sel; b_dat = wdat;
    tgt = w; b_cyc = 1'b1; b_stb = 1'b1;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_v[w] || err_v[w]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: inst %0d adr %h got no response want ack/err", w, adr);
      sb.delete();
    end
    if (!keep) begin
      b_cyc = 1'b0; b_stb = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int r0;
    rst_n = 1'b1;
    b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0; b_stb = 1'b0; b_cyc = 1'b0; tgt = 0;
    for (int w = 0; w < 4; w++) begin
      resp_cnt[w] = 0;
      last_dat[w] = 16'h0000;
    end
    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    #1;
    for (int w = 0; w < 4; w++) begin
      check($sformatf("rst_ack%0d", w), 32'(ack_v[w]), 32'd0);
      check($sformatf("rst_err%0d", w), 32'(err_v[w]), 32'd0);
      check($sformatf("rst_dat%0d", w), 32'(dat_v[w]), 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 4; w++) begin
      xfer(w, 32'h1000, 1'b1, 2'b11, 16'h0100, 1'b0, 16'h0, 1'b0);
      xfer(w, 32'h1002, 1'b1, 2'b11, 16'h1234, 1'b0, 16'h0, 1'b0);
      xfer(w, 32'h1004, 1'b1, 2'b11, 16'h5678, 1'b0, 16'h0, 1'b0);
      xfer(w, 32'h1010, 1'b1, 2'b11, 16'h1111, 1'b0, 16'h0, 1'b0);
      xfer(w, 32'h1020, 1'b1, 2'b11, 16'h4444, 1'b0, 16'h0, 1'b0);
      xfer(w, 32'h2FFE, 1'b1, 2'b11, 16'h7E57, 1'b0, 16'h0, 1'b0);
    end

    xfer(1, 32'h1000, 1'b0, 2'b11, 16'h0, 1'b0, 16'h0100, 1'b0);

    xfer(1, 32'h1002, 1'b1, 2'b10, 16'hABCD, 1'b0, 16'h0, 1'b0);
    xfer(1, 32'h1002, 1'b0, 2'b00, 16'h0, 1'b0, 16'hAB34, 1'b0);
    xfer(1, 32'h1006, 1'b1, 2'b11, 16'hC0DE, 1'b0, 16'h0, 1'b0);
    xfer(1, 32'h1006, 1'b1, 2'b01, 16'hEEFF, 1'b0, 16'h0, 1'b0);
    xfer(1, 32'h1006, 1'b0, 2'b11, 16'h0, 1'b0, 16'hC0FF, 1'b0);

    xfer(1, 32'h0FFE, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0, 1'b0);
    xfer(1, 32'h1001, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0, 1'b0);
    xfer(1, 32'h3000, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0, 1'b0);
    xfer(1, 32'h1003, 1'b1, 2'b11, 16'h0000, 1'b1, 16'h0, 1'b0);
    xfer(1, 32'h3000, 1'b1, 2'b11, 16'hDEAD, 1'b1, 16'h0, 1'b0);
    xfer(1, 32'h1002, 1'b0, 2'b11, 16'h0, 1'b0, 16'hAB34, 1'b0);
    xfer(1, 32'h2FFE, 1'b0, 2'b11, 16'h0, 1'b0, 16'h7E57, 1'b0);
    xfer(3, 32'h3000, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0, 1'b0);
    xfer(0, 32'h0FFE, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0, 1'b0);

    r0 = resp_cnt[0];
    tgt = 0; b_adr = 32'h1000; b_we = 1'b0; b_cyc = 1'b1; b_stb = 1'b0;
    repeat (5) @(negedge clk);
    b_cyc = 1'b0;
    check("stb_low_no_resp", 32'(resp_cnt[0]), 32'(r0));
    @(negedge clk);

    r0 = resp_cnt[3];
    tgt = 3; b_adr = 32'h1010; b_we = 1'b1; b_sel = 2'b11; b_dat = 16'h2222;
    b_cyc = 1'b1; b_stb = 1'b1;
    repeat (2) @(negedge clk);
    b_cyc = 1'b0; b_stb = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_resp", 32'(resp_cnt[3]), 32'(r0));
    xfer(3, 32'h1010, 1'b0, 2'b11, 16'h0, 1'b0, 16'h1111, 1'b0);
    xfer(3, 32'h1010, 1'b1, 2'b11, 16'h2222, 1'b0, 16'h0, 1'b0);
    xfer(3, 32'h1010, 1'b0, 2'b11, 16'h0, 1'b0, 16'h2222, 1'b0);

    r0 = resp_cnt[2];
    tgt = 2; b_adr = 32'h1020; b_we = 1'b1; b_sel = 2'b11; b_dat = 16'h3333;
    b_cyc = 1'b1; b_stb = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dat1", 32'(dat_v[1]), 32'h0);
    check("midrst_dat3", 32'(dat_v[3]), 32'h0);
    check("midrst_ack2", 32'(ack_v[2]), 32'd0);
    b_cyc = 1'b0; b_stb = 1'b0;
    for (int w = 0; w < 4; w++) last_dat[w] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_resp", 32'(resp_cnt[2]), 32'(r0));
    xfer(2, 32'h1020, 1'b0, 2'b11, 16'h0, 1'b0, 16'h4444, 1'b0);

    for (int w = 0; w < 4; w++) begin
      xfer(w, 32'h1000, 1'b0, 2'b11, 16'h0, 1'b0, 16'h0100, 1'b1);
      xfer(w, 32'h1002, 1'b0, 2'b11, 16'h0, 1'b0, (w == 1) ? 16'hAB34 : 16'h1234, 1'b1);
      xfer(w, 32'h1004, 1'b0, 2'b11, 16'h0, 1'b0, 16'h5678, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
